// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory access unit.
package mem_pkg;

  // Bus-side sequencing of one load/store held in the MEM stage
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  // result_src encoding that marks a load in the MEM stage
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  // One strobe per byte of a 32-bit bus word
  localparam int BE_WIDTH = 4;

  // A word access is legal only on a 4-byte boundary
  function automatic logic word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational byte-lane steering: store strobes/replication and
// load lane extraction with sign extension.
module byte_lane_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  st_byte,
  input  logic [1:0]            st_lane,
  input  logic [DATA_WIDTH-1:0] st_data,
  output logic [BE_WIDTH-1:0]   st_be,
  output logic [DATA_WIDTH-1:0] st_wdata,
  input  logic                  ld_byte,
  input  logic [1:0]            ld_lane,
  input  logic [DATA_WIDTH-1:0] ld_rdata,
  output logic [DATA_WIDTH-1:0] ld_data
);

  localparam logic [BE_WIDTH-1:0] BE_LANE0 = BE_WIDTH'(1);

  logic [7:0] ld_sel;

  // Store side: one strobe and the low byte copied to every lane for byte stores
  always_comb begin
    st_be    = '1;
    st_wdata = st_data;
    if (st_byte) begin
      st_be    = BE_LANE0 << st_lane;
      st_wdata = {(DATA_WIDTH/8){st_data[7:0]}};
    end
  end

  // Load side: pick the addressed lane and sign-extend it for byte loads
  always_comb begin
    case (ld_lane)
      2'd0:    ld_sel = ld_rdata[7:0];
      2'd1:    ld_sel = ld_rdata[15:8];
      2'd2:    ld_sel = ld_rdata[23:16];
      default: ld_sel = ld_rdata[31:24];
    endcase
    ld_data = ld_rdata;
    if (ld_byte) begin
      ld_data = {{(DATA_WIDTH-8){ld_sel[7]}}, ld_sel};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-bus access unit: stalls the pipeline while a load or
// store is carried out over a req/gnt/rvalid bus.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] alu_result_m_i,
  input  logic [DATA_WIDTH-1:0] write_data_m_i,
  input  logic [1:0]            result_src_m_i,
  input  logic                  mem_write_m_i,
  input  logic                  byte_op_m_i,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [DATA_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  output logic [BE_WIDTH-1:0]   bus_be_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i,
  output logic [DATA_WIDTH-1:0] read_data_m_o,
  output logic                  stall_o,
  output logic                  err_o
);

  mem_state_e            state_reg;
  logic                  req_reg;
  logic                  we_reg;
  logic                  byte_reg;
  logic [1:0]            lane_reg;
  logic [DATA_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [BE_WIDTH-1:0]   be_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;

  logic                  access;
  logic                  aligned;
  logic                  start;
  logic                  misaligned;
  logic [BE_WIDTH-1:0]   st_be;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [DATA_WIDTH-1:0] ld_data;

  // A store wins over a load when both are flagged; only the type bit matters here
  assign access     = mem_write_m_i || (result_src_m_i == RESULT_SRC_MEM);
  assign aligned    = byte_op_m_i || word_aligned(alu_result_m_i[1:0]);
  assign start      = (state_reg == IDLE) && access && aligned;
  assign misaligned = (state_reg == IDLE) && access && !aligned;

  // Store lanes come from the live instruction (latched on start);
  // load lanes come from the latched access so rdata is steered correctly later
  byte_lane_unit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_byte_lane (
    .st_byte (byte_op_m_i),
    .st_lane (alu_result_m_i[1:0]),
    .st_data (write_data_m_i),
    .st_be   (st_be),
    .st_wdata(st_wdata),
    .ld_byte (byte_reg),
    .ld_lane (lane_reg),
    .ld_rdata(bus_rdata_i),
    .ld_data (ld_data)
  );

  // Access sequencer: latch in IDLE, hold the request until gnt, capture read data, one DONE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      byte_reg  <= 1'b0;
      lane_reg  <= 2'b00;
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
      rdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= REQ;
            req_reg   <= 1'b1;
            we_reg    <= mem_write_m_i;
            byte_reg  <= byte_op_m_i;
            lane_reg  <= alu_result_m_i[1:0];
            addr_reg  <= {alu_result_m_i[DATA_WIDTH-1:2], 2'b00};
            wdata_reg <= st_wdata;
            be_reg    <= st_be;
          end
        end
        REQ: begin
          if (bus_gnt_i) begin
            req_reg <= 1'b0;
            if (we_reg) begin
              state_reg <= DONE;
            end else if (bus_rvalid_i) begin
              // Zero-latency read: data arrives together with the grant
              rdata_reg <= ld_data;
              state_reg <= DONE;
            end else begin
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus_rvalid_i) begin
            rdata_reg <= ld_data;
            state_reg <= DONE;
          end
        end
        DONE: begin
          // Stall drops here so the held instruction leaves; never re-examine it
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus_req_o     = req_reg;
  assign bus_we_o      = we_reg;
  assign bus_addr_o    = addr_reg;
  assign bus_wdata_o   = wdata_reg;
  assign bus_be_o      = be_reg;
  assign read_data_m_o = rdata_reg;

  // Stall rises in the accepting IDLE cycle so the upstream registers freeze immediately
  assign stall_o = rst_n && (start || (state_reg == REQ) || (state_reg == WAIT));
  assign err_o   = rst_n && misaligned;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver acts as pipeline and bus
// slave, a monitor pops expected results as transfers complete.
module tb_mem_access_unit;
  import mem_pkg::*;

  typedef struct {
    logic        is_err;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;
    int          req;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_result_m_i;
  logic [31:0] write_data_m_i;
  logic [1:0]  result_src_m_i;
  logic        mem_write_m_i;
  logic        byte_op_m_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic [31:0] read_data_m_o;
  logic        stall_o;
  logic        err_o;

  int          n_checks = 0;
  int          n_errors = 0;
  int          txn_n    = 0;
  bit          mon_en   = 0;
  logic [31:0] last_rd  = 32'h0;
  exp_t        sb[$];

  mem_access_unit #(.DATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_result_m_i(alu_result_m_i),
    .write_data_m_i(write_data_m_i),
    .result_src_m_i(result_src_m_i),
    .mem_write_m_i (mem_write_m_i),
    .byte_op_m_i   (byte_op_m_i),
    .bus_req_o     (bus_req_o),
    .bus_we_o      (bus_we_o),
    .bus_addr_o    (bus_addr_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_be_o      (bus_be_o),
    .bus_gnt_i     (bus_gnt_i),
    .bus_rvalid_i  (bus_rvalid_i),
    .bus_rdata_i   (bus_rdata_i),
    .read_data_m_o (read_data_m_o),
    .stall_o       (stall_o),
    .err_o         (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t make_exp(input logic mw, input logic [1:0] rs, input logic bo,
                                    input logic [31:0] a, input logic [31:0] wd,
                                    input logic [31:0] rd, input int gd, input int rv,
                                    input logic same, input logic [31:0] prev_rd);
    exp_t e;
    logic [7:0] b;
    e.we     = mw;
    e.addr   = a & 32'hFFFF_FFFC;
    e.is_err = (mw || (rs == 2'b01)) && !bo && (a[1:0] != 2'b00);
    case (a[1:0])
      2'd0:    begin e.be = 4'b0001; b = rd[7:0];   end
      2'd1:    begin e.be = 4'b0010; b = rd[15:8];  end
      2'd2:    begin e.be = 4'b0100; b = rd[23:16]; end
      default: begin e.be = 4'b1000; b = rd[31:24]; end
    endcase
    if (!bo) e.be = 4'hF;
    e.wdata = bo ? {wd[7:0], wd[7:0], wd[7:0], wd[7:0]} : wd;
    e.rdata = prev_rd;
    if (!mw && !e.is_err) e.rdata = bo ? {{24{b[7]}}, b} : rd;
    if (e.is_err)         e.stall = 0;
    else if (mw || same)  e.stall = 2 + gd;
    else                  e.stall = 3 + gd + rv;
    e.req = e.is_err ? 0 : gd + 1;
    return e;
  endfunction

  task automatic idle_inputs();
    mem_write_m_i  = 1'b0;
    result_src_m_i = 2'b00;
    byte_op_m_i    = 1'b0;
    alu_result_m_i = 32'h0;
    write_data_m_i = 32'h0;
    bus_gnt_i      = 1'b0;
    bus_rvalid_i   = 1'b0;
  endtask

  // Called at posedge+1; holds the instruction until stall_o is seen low, answers the bus
  task automatic run_txn(input logic mw, input logic [1:0] rs, input logic bo,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int gd, input int rv, input logic same, input logic junk);
    exp_t e;
    logic st;
    logic granted;
    logic retired;
    int   req_n;
    int   wait_n;
    e = make_exp(mw, rs, bo, a, wd, rd, gd, rv, same, last_rd);
    last_rd = e.rdata;
    sb.push_back(e);
    mem_write_m_i  = mw;
    result_src_m_i = rs;
    byte_op_m_i    = bo;
    alu_result_m_i = a;
    write_data_m_i = wd;
    granted = 1'b0;
    retired = 1'b0;
    req_n   = 0;
    wait_n  = 0;
    for (int c = 0; c < 64 && !retired; c++) begin
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = $urandom;
      if (bus_req_o) begin
        if (req_n == gd) begin
          bus_gnt_i = 1'b1;
          granted   = 1'b1;
          if (!mw && same) begin
            bus_rvalid_i = 1'b1;
            bus_rdata_i  = rd;
          end
        end else if (junk) begin
          bus_rvalid_i = 1'b1;
        end
        req_n++;
      end else if (granted && !mw && !same) begin
        if (wait_n == rv) begin
          bus_rvalid_i = 1'b1;
          bus_rdata_i  = rd;
        end
        wait_n++;
      end
      @(negedge clk);
      st = stall_o;
      @(posedge clk);
      #1;
      if (!st) retired = 1'b1;
    end
    check("txn_retired", {31'b0, retired}, 32'h1);
    idle_inputs();
    check("sb_drain", sb.size(), 32'h0);
  endtask

  // Monitor: checks bus fields during REQ, pops the scoreboard on DONE or on an err pulse
  initial begin : monitor
    logic prev_stall;
    int   stall_cnt;
    int   req_cnt;
    exp_t e;
    prev_stall = 1'b0;
    stall_cnt  = 0;
    req_cnt    = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (bus_req_o && !stall_o) check("req_without_stall", {31'b0, bus_req_o}, 32'h0);
        if (err_o) begin
          if (sb.size() == 0) begin
            check("sb_underflow_err", sb.size(), 32'h1);
          end else begin
            e = sb.pop_front();
            txn_n++;
            check("err_flag", {31'b0, err_o}, {31'b0, e.is_err});
            check("err_stall", {31'b0, stall_o}, 32'h0);
            check("err_rdata_hold", read_data_m_o, e.rdata);
            $display("txn %0d: misaligned addr=0x%08h err", txn_n, e.addr);
          end
        end else if (stall_o) begin
          if (!prev_stall) begin
            stall_cnt = 0;
            req_cnt   = 0;
          end
          stall_cnt++;
          if (bus_req_o && sb.size() > 0) begin
            req_cnt++;
            e = sb[0];
            check("bus_addr", bus_addr_o, e.addr);
            check("bus_be", {28'b0, bus_be_o}, {28'b0, e.be});
            check("bus_we", {31'b0, bus_we_o}, {31'b0, e.we});
            if (e.we) check("bus_wdata", bus_wdata_o, e.wdata);
          end
        end else if (prev_stall) begin
          if (sb.size() == 0) begin
            check("sb_underflow_done", sb.size(), 32'h1);
          end else begin
            e = sb.pop_front();
            txn_n++;
            check("stall_cycles", stall_cnt, e.stall);
            check("req_cycles", req_cnt, e.req);
            check("done_rdata", read_data_m_o, e.rdata);
            check("done_err", {31'b0, err_o}, 32'h0);
            $display("txn %0d: %s addr=0x%08h be=%b stall=%0d rdata=0x%08h",
                     txn_n, e.we ? "store" : "load", e.addr, e.be, stall_cnt, read_data_m_o);
          end
        end
        prev_stall = stall_o;
      end
    end
  end

  initial begin : driver
    logic       mw;
    logic       bo;
    logic [31:0] a;
    rst_n       = 1'b0;
    bus_rdata_i = 32'h0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'b0, bus_req_o}, 32'h0);
    check("rst_we", {31'b0, bus_we_o}, 32'h0);
    check("rst_stall", {31'b0, stall_o}, 32'h0);
    check("rst_err", {31'b0, err_o}, 32'h0);
    check("rst_be", {28'b0, bus_be_o}, 32'h0);
    check("rst_addr", bus_addr_o, 32'h0);
    check("rst_wdata", bus_wdata_o, 32'h0);
    check("rst_rdata", read_data_m_o, 32'h0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    //       mw    rs     bo    addr          wdata         rdata         gd rv same junk
    run_txn(1'b1, 2'b00, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 0, 1'b0, 1'b0);
    run_txn(1'b0, 2'b01, 1'b1, 32'h0000_0103, 32'h0,         32'h80FF_0000, 0, 0, 1'b0, 1'b0);
    run_txn(1'b1, 2'b00, 1'b1, 32'h0000_0102, 32'h0000_00A5, 32'h0,        4, 0, 1'b0, 1'b0);
    run_txn(1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0,         32'h5555_5555, 0, 0, 1'b0, 1'b0);
    run_txn(1'b0, 2'b01, 1'b0, 32'h0000_0040, 32'h0,         32'h1234_5678, 0, 0, 1'b1, 1'b0);
    run_txn(1'b0, 2'b01, 1'b1, 32'h0000_0204, 32'h0,         32'h1122_337F, 2, 2, 1'b0, 1'b1);
    run_txn(1'b0, 2'b01, 1'b1, 32'h0000_0205, 32'h0,         32'h0000_C100, 1, 0, 1'b0, 1'b1);
    run_txn(1'b1, 2'b01, 1'b1, 32'h0000_0301, 32'h1234_5678, 32'h0,        0, 0, 1'b0, 1'b0);
    run_txn(1'b1, 2'b00, 1'b0, 32'h0000_0102, 32'hCAFE_0001, 32'h0,        0, 0, 1'b0, 1'b0);
    run_txn(1'b0, 2'b01, 1'b0, 32'h0000_0FF0, 32'h0,         32'hA0B0_C0D0, 3, 1, 1'b0, 1'b1);

    // Not an access: result_src other than the load code, no write
    result_src_m_i = 2'b10;
    alu_result_m_i = 32'h0000_0400;
    repeat (2) begin
      @(negedge clk);
      check("noacc_stall", {31'b0, stall_o}, 32'h0);
      check("noacc_req", {31'b0, bus_req_o}, 32'h0);
      @(posedge clk);
      #1;
    end
    idle_inputs();

    // Stray rvalid while idle must not disturb the held load result
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h7777_7777;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus_rvalid_i = 1'b0;
    @(negedge clk);
    check("stray_rvalid_hold", read_data_m_o, last_rd);
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      mw = 1'($urandom_range(0, 1));
      bo = 1'($urandom_range(0, 1));
      a  = $urandom & 32'h0000_0FFF;
      if (!bo) a[1:0] = 2'b00;
      run_txn(mw, mw ? 2'b00 : 2'b01, bo, a, $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset while waiting for read data: transfer is abandoned
    mon_en         = 1'b0;
    result_src_m_i = 2'b01;
    alu_result_m_i = 32'h0000_0200;
    @(posedge clk);
    #1;
    check("rstw_req", {31'b0, bus_req_o}, 32'h1);
    bus_gnt_i = 1'b1;
    @(posedge clk);
    #1;
    bus_gnt_i = 1'b0;
    check("rstw_wait_stall", {31'b0, stall_o}, 32'h1);
    check("rstw_wait_req", {31'b0, bus_req_o}, 32'h0);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("rstw_state", 32'(dut.state_reg), 32'(IDLE));
    check("rstw_stall", {31'b0, stall_o}, 32'h0);
    check("rstw_rdata", read_data_m_o, 32'h0);
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hCAFE_F00D;
    @(negedge clk);
    check("rstw_rv_rdata", read_data_m_o, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rstw_rel_rdata", read_data_m_o, 32'h0);
    check("rstw_rel_stall", {31'b0, stall_o}, 32'h0);
    check("rstw_rel_req", {31'b0, bus_req_o}, 32'h0);
    @(posedge clk);
    #1;
    bus_rvalid_i = 1'b0;
    @(negedge clk);
    check("rstw_after_state", 32'(dut.state_reg), 32'(IDLE));
    check("rstw_after_rdata", read_data_m_o, 32'h0);
    last_rd = 32'h0;
    sb.delete();
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // First access after reset starts from IDLE with full latency
    run_txn(1'b0, 2'b01, 1'b1, 32'h0000_0302, 32'h0, 32'h00F0_0000, 0, 0, 1'b0, 1'b0);
    run_txn(1'b1, 2'b00, 1'b0, 32'h0000_0304, 32'h0BAD_F00D, 32'h0, 1, 0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    check("sb_final_empty", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
